// File: rtl/pipe_hazard_ctrl.sv
// Pipeline control for an ID/EX/MEM/WB integer pipe: carries decoded control to WB,
// stalls on load-use, resolves branches/jumps in EX and selects EX operand forwarding.
module pipe_hazard_ctrl #(
    parameter int REG_AW   = 3,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [10:0]       id_ctrl,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              ex_zero,
    output logic              stall,
    output logic              flush,
    output logic [1:0]        pc_sel,
    output logic [10:0]       ex_ctrl,
    output logic [3:0]        mem_ctrl,
    output logic [1:0]        wb_ctrl,
    output logic [2:0]        stg_valid,
    output logic [REG_AW-1:0] wb_dest,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b
);

    localparam int B_REG_DST   = 8;
    localparam int B_ALU_SRC   = 7;
    localparam int B_MEM_READ  = 6;
    localparam int B_MEM_WRITE = 5;
    localparam int B_REG_WRITE = 3;
    localparam int B_JUMP      = 2;
    localparam int B_BNE       = 1;
    localparam int B_BEQ       = 0;

    // A destination can only create a dependency if it is a writable register.
    function automatic logic dest_live(input logic [REG_AW-1:0] d);
        return (ZERO_REG == 1'b0) || (d != '0);
    endfunction

    logic              vld_p0, vld_p1, vld_p2;
    logic [10:0]       ctrl_p0;
    logic [3:0]        ctrl_p1;
    logic [1:0]        ctrl_p2;
    logic [REG_AW-1:0] dest_p0, rs_p0, rt_p0, dest_p1, dest_p2;

    logic              id_dest_sel;
    logic [REG_AW-1:0] id_dest;
    logic              rs_used, rt_used, load_use, taken, ex_load;
    logic              mem_fwd_ok, wb_fwd_ok;

    always_comb begin
        id_dest_sel = id_ctrl[B_REG_DST];
        id_dest     = id_dest_sel ? id_rd : id_rt;
        rs_used     = id_valid;
        rt_used     = id_valid & (~id_ctrl[B_ALU_SRC] | id_ctrl[B_MEM_WRITE]
                                  | id_ctrl[B_BEQ] | id_ctrl[B_BNE]);

        load_use = vld_p0 & ctrl_p0[B_MEM_READ] & ctrl_p0[B_REG_WRITE] & dest_live(dest_p0)
                   & ((rs_used & (id_rs == dest_p0)) | (rt_used & (id_rt == dest_p0)));

        taken = vld_p0 & (ctrl_p0[B_JUMP] | (ctrl_p0[B_BEQ] & ex_zero)
                          | (ctrl_p0[B_BNE] & ~ex_zero));

        // A taken branch squashes the ID instruction, so its hazard is moot.
        flush   = taken;
        stall   = load_use & ~taken;
        pc_sel  = taken ? (ctrl_p0[B_JUMP] ? 2'b10 : 2'b01) : 2'b00;
        ex_load = id_valid & ~stall & ~flush;

        mem_fwd_ok = vld_p1 & ctrl_p1[0] & dest_live(dest_p1);
        wb_fwd_ok  = vld_p2 & ctrl_p2[0] & dest_live(dest_p2);

        fwd_a = (mem_fwd_ok && dest_p1 == rs_p0) ? 2'b10 :
                (wb_fwd_ok  && dest_p2 == rs_p0) ? 2'b01 : 2'b00;
        fwd_b = (mem_fwd_ok && dest_p1 == rt_p0) ? 2'b10 :
                (wb_fwd_ok  && dest_p2 == rt_p0) ? 2'b01 : 2'b00;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p0  <= 1'b0;
            ctrl_p0 <= '0;
            dest_p0 <= '0;
            rs_p0   <= '0;
            rt_p0   <= '0;
            vld_p1  <= 1'b0;
            ctrl_p1 <= '0;
            dest_p1 <= '0;
            vld_p2  <= 1'b0;
            ctrl_p2 <= '0;
            dest_p2 <= '0;
        end else begin
            // ID -> EX: bubbles carry all-zero control and addresses
            vld_p0  <= ex_load;
            ctrl_p0 <= ex_load ? id_ctrl : '0;
            dest_p0 <= ex_load ? id_dest : '0;
            rs_p0   <= ex_load ? id_rs   : '0;
            rt_p0   <= ex_load ? id_rt   : '0;
            // EX -> MEM
            vld_p1  <= vld_p0;
            ctrl_p1 <= ctrl_p0[6:3];
            dest_p1 <= dest_p0;
            // MEM -> WB
            vld_p2  <= vld_p1;
            ctrl_p2 <= ctrl_p1[1:0];
            dest_p2 <= dest_p1;
        end
    end

    assign ex_ctrl   = vld_p0 ? ctrl_p0 : '0;
    assign mem_ctrl  = vld_p1 ? ctrl_p1 : '0;
    assign wb_ctrl   = vld_p2 ? ctrl_p2 : '0;
    assign stg_valid = {vld_p2, vld_p1, vld_p0};
    assign wb_dest   = dest_p2;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: reset, load-use stall, forwarding priority,
// branch/jump resolution, flush-over-stall priority, register-0 handling and mid-run reset.
module tb_pipe_hazard_ctrl;

    localparam logic [10:0] C_LW  = 11'b10_0_1_1_0_1_1_0_0_0;
    localparam logic [10:0] C_ADD = 11'b10_1_0_0_0_0_1_0_0_0;
    localparam logic [10:0] C_BEQ = 11'b01_0_0_0_0_0_0_0_0_1;
    localparam logic [10:0] C_BNE = 11'b01_0_0_0_0_0_0_0_1_0;
    localparam logic [10:0] C_JL  = 11'b10_0_1_1_0_1_1_1_0_0;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [10:0] id_ctrl;
    logic [2:0]  id_rs, id_rt, id_rd;
    logic        ex_zero;
    logic        stall, flush;
    logic [1:0]  pc_sel;
    logic [10:0] ex_ctrl;
    logic [3:0]  mem_ctrl;
    logic [1:0]  wb_ctrl;
    logic [2:0]  stg_valid;
    logic [2:0]  wb_dest;
    logic [1:0]  fwd_a, fwd_b;

    int vecs = 0;
    int errs = 0;

    pipe_hazard_ctrl #(.REG_AW(3), .ZERO_REG(1'b1)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_ctrl(id_ctrl),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .ex_zero(ex_zero),
        .stall(stall), .flush(flush), .pc_sel(pc_sel), .ex_ctrl(ex_ctrl),
        .mem_ctrl(mem_ctrl), .wb_ctrl(wb_ctrl), .stg_valid(stg_valid),
        .wb_dest(wb_dest), .fwd_a(fwd_a), .fwd_b(fwd_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic id(input logic v, input logic [10:0] c,
                      input logic [2:0] rs, input logic [2:0] rt, input logic [2:0] rd);
        id_valid = v; id_ctrl = c; id_rs = rs; id_rt = rt; id_rd = rd;
        #1;
    endtask

    initial begin
        // Reset with junk on every input
        rst = 1'b1; ex_zero = 1'b1;
        id(1'b1, C_JL, 3'd5, 3'd5, 3'd5);
        tick(); tick();
        rst = 1'b0;
        #1;
        chk("rst_stall", 16'(stall), 16'd0);
        chk("rst_flush", 16'(flush), 16'd0);
        chk("rst_pc_sel", 16'(pc_sel), 16'd0);
        chk("rst_ex_ctrl", 16'(ex_ctrl), 16'd0);
        chk("rst_mem_ctrl", 16'(mem_ctrl), 16'd0);
        chk("rst_wb_ctrl", 16'(wb_ctrl), 16'd0);
        chk("rst_stg_valid", 16'(stg_valid), 16'd0);
        chk("rst_wb_dest", 16'(wb_dest), 16'd0);
        chk("rst_fwd_a", 16'(fwd_a), 16'd0);
        chk("rst_fwd_b", 16'(fwd_b), 16'd0);

        // Load-use: LW r2 then ADD r3 = r2 + r1
        id(1'b1, C_LW, 3'd1, 3'd2, 3'd0);
        chk("lw_id_stall", 16'(stall), 16'd0);
        tick();
        id(1'b1, C_ADD, 3'd2, 3'd1, 3'd3);
        chk("lu_stall", 16'(stall), 16'd1);
        chk("lu_flush", 16'(flush), 16'd0);
        chk("lu_ex_ctrl", 16'(ex_ctrl), 16'(C_LW));
        chk("lu_stg_valid", 16'(stg_valid), 16'b001);
        tick();
        chk("lu_recheck_stall", 16'(stall), 16'd0);
        chk("lu_bubble_valid", 16'(stg_valid), 16'b010);
        chk("lu_bubble_ex_ctrl", 16'(ex_ctrl), 16'd0);
        chk("lu_mem_ctrl", 16'(mem_ctrl), 16'b1011);
        tick();
        chk("lu_fwd_a_wb", 16'(fwd_a), 16'b01);
        chk("lu_fwd_b", 16'(fwd_b), 16'b00);
        chk("lu_stg_valid2", 16'(stg_valid), 16'b101);
        chk("lu_wb_ctrl", 16'(wb_ctrl), 16'b11);
        chk("lu_wb_dest", 16'(wb_dest), 16'd2);
        chk("lu_ex_add", 16'(ex_ctrl), 16'(C_ADD));

        // MEM vs WB forwarding: ADD r1, ADD r1, SUB r6 = r1 - r3
        id(1'b1, C_ADD, 3'd4, 3'd5, 3'd1);
        tick();
        id(1'b1, C_ADD, 3'd6, 3'd7, 3'd1);
        tick();
        id(1'b1, C_ADD, 3'd1, 3'd3, 3'd6);
        tick();
        chk("mw_fwd_a_mem", 16'(fwd_a), 16'b10);
        chk("mw_fwd_b_none", 16'(fwd_b), 16'b00);
        chk("mw_wb_dest", 16'(wb_dest), 16'd1);

        // BEQ taken, then BNE not taken / taken
        id(1'b1, C_BEQ, 3'd1, 3'd1, 3'd0);
        tick();
        ex_zero = 1'b1;
        id(1'b1, C_ADD, 3'd2, 3'd2, 3'd5);
        chk("beq_flush", 16'(flush), 16'd1);
        chk("beq_pc_sel", 16'(pc_sel), 16'b01);
        chk("beq_stall", 16'(stall), 16'd0);
        chk("beq_fwd_a_wb", 16'(fwd_a), 16'b01);
        tick();
        chk("beq_bubble_ex_ctrl", 16'(ex_ctrl), 16'd0);
        chk("beq_stg_valid", 16'(stg_valid), 16'b110);
        chk("beq_mem_ctrl", 16'(mem_ctrl), 16'd0);
        chk("beq_wb_ctrl_sub", 16'(wb_ctrl), 16'b01);
        chk("beq_wb_dest", 16'(wb_dest), 16'd6);
        id(1'b1, C_BNE, 3'd1, 3'd2, 3'd0);
        tick();
        chk("bne_z1_flush", 16'(flush), 16'd0);
        chk("bne_z1_pc_sel", 16'(pc_sel), 16'b00);
        ex_zero = 1'b0;
        #1;
        chk("bne_z0_flush", 16'(flush), 16'd1);
        chk("bne_z0_pc_sel", 16'(pc_sel), 16'b01);
        ex_zero = 1'b1;

        // Jump in EX that is also a load whose dest is used in ID
        id(1'b1, C_JL, 3'd0, 3'd4, 3'd0);
        tick();
        id(1'b1, C_ADD, 3'd4, 3'd1, 3'd3);
        chk("col_stall", 16'(stall), 16'd0);
        chk("col_flush", 16'(flush), 16'd1);
        chk("col_pc_sel", 16'(pc_sel), 16'b10);
        tick();
        chk("col_bubble", 16'(stg_valid[0]), 16'd0);

        // Register 0 never stalls or forwards
        id(1'b1, C_LW, 3'd1, 3'd0, 3'd0);
        tick();
        id(1'b1, C_ADD, 3'd0, 3'd0, 3'd7);
        chk("z_stall", 16'(stall), 16'd0);
        tick();
        chk("z_fwd_a_mem", 16'(fwd_a), 16'b00);
        chk("z_fwd_b_mem", 16'(fwd_b), 16'b00);
        chk("z_stall2", 16'(stall), 16'd0);
        tick();
        chk("z_fwd_a_wb", 16'(fwd_a), 16'b00);

        // Invalid ID never stalls; then reset squashes a full pipe
        id(1'b1, C_LW, 3'd1, 3'd5, 3'd0);
        tick();
        id(1'b0, C_ADD, 3'd5, 3'd5, 3'd2);
        chk("inv_no_stall", 16'(stall), 16'd0);
        id(1'b1, C_ADD, 3'd5, 3'd5, 3'd2);
        chk("val_stall", 16'(stall), 16'd1);
        chk("full_stg_valid", 16'(stg_valid), 16'b111);
        rst = 1'b1;
        tick();
        chk("mid_rst_valid", 16'(stg_valid), 16'd0);
        chk("mid_rst_ex_ctrl", 16'(ex_ctrl), 16'd0);
        chk("mid_rst_wb_ctrl", 16'(wb_ctrl), 16'd0);
        chk("mid_rst_stall", 16'(stall), 16'd0);
        rst = 1'b0;
        tick();
        chk("post_rst_wb_ctrl", 16'(wb_ctrl), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
